// File: rtl/instruction_cache_if.sv
// Block-read handshake between the instruction cache (master) and the
// 16-byte-block instruction memory (slave).
interface instruction_cache_if;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinst;
    logic         mem_busywait;

    modport master (
        output mem_read,
        output mem_address,
        input  mem_readinst,
        input  mem_busywait
    );

    modport slave (
        input  mem_read,
        input  mem_address,
        output mem_readinst,
        output mem_busywait
    );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache, 8 lines x 16 B, single-cycle hits.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module instruction_cache (
    input  logic                 clock,
    input  logic                 reset,
    instruction_cache_if.master  mem,
    input  logic                 read,
    input  logic [9:0]           address,
    output logic [31:0]          instruction,
    output logic                 busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
`endif
);

    localparam int LINES  = 8;
    localparam int LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_t;

    state_t              state_q;
    logic [LINES-1:0]    valid_q;
    logic [2:0]          tag_q  [LINES];
    logic [LINE_W-1:0]   data_q [LINES];
    logic [2:0]          miss_tag_q;
    logic [2:0]          miss_index_q;
    logic                mem_read_q;
    logic                busy_q;

    logic [2:0]          tag;
    logic [2:0]          index;
    logic [1:0]          offset;
    logic                hit;
    logic                miss;
    logic [LINE_W-1:0]   line;
    logic                unused_addr_bits;

    assign tag              = address[9:7];
    assign index            = address[6:4];
    assign offset           = address[3:2];
    assign unused_addr_bits = ^address[1:0];

    assign hit  = read & valid_q[index] & (tag_q[index] == tag);
    assign miss = read & ~hit;
    assign line = data_q[index];

    assign instruction = reset ? 32'd0 : line[32*offset +: 32];
    assign busywait    = ~reset & (busy_q | miss);

    assign mem.mem_read    = mem_read_q;
    assign mem.mem_address = {miss_tag_q, miss_index_q};

    // Control FSM: busy_q covers the MEM_READ and UPDATE cycles of a miss.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            mem_read_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        miss_tag_q   <= tag;
                        miss_index_q <= index;
                        mem_read_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (!mem.mem_busywait) begin
                        mem_read_q <= 1'b0;
                        state_q    <= UPDATE;
                    end
                end
                UPDATE: begin
                    valid_q[miss_index_q] <= 1'b1;
                    busy_q                <= 1'b0;
                    state_q               <= IDLE;
                end
                default: begin
                    mem_read_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays are not reset; valid_q alone decides whether a line counts.
    always_ff @(posedge clock) begin
        if (state_q == UPDATE) begin
            tag_q[miss_index_q]  <= miss_tag_q;
            data_q[miss_index_q] <= mem.mem_readinst;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt_q,  hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == IDLE) begin
            if (hit)  hit_cnt_d  = sat_inc(hit_cnt_q);
            if (miss) miss_cnt_d = sat_inc(miss_cnt_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: cycle-level reference model plus
// directed accesses with hand-computed instruction words.
module tb_instruction_cache;

    logic        clock = 1'b0;
    logic        reset;
    logic        read;
    logic [9:0]  address;
    logic [31:0] instruction;
    logic        busywait;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int errors = 0;
    int checks = 0;
    int lat    = 3;
    int mcnt   = 0;

    instruction_cache_if mif ();

    always #5 clock = ~clock;

    instruction_cache dut (
        .clock       (clock),
        .reset       (reset),
        .mem         (mif),
        .read        (read),
        .address     (address),
        .instruction (instruction),
        .busywait    (busywait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    // Memory contents: block 0 word 0 is 00040019, everything else A0_0000 | blk<<8 | word.
    function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] w);
        if (blk == 6'd0 && w == 2'd0) return 32'h00040019;
        return {8'hA0, 10'h000, blk, 6'h00, w};
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++)
            mif.mem_readinst[32*k +: 32] = mem_word(mif.mem_address, k[1:0]);
    end

    assign mif.mem_busywait = mif.mem_read && (mcnt < lat);

    always @(posedge clock) begin
        if (!mif.mem_read)  mcnt <= 0;
        else if (mcnt < lat) mcnt <= mcnt + 1;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a miss keeps the CPU stalled for lat+3 cycles, then the line is present.
    bit         m_valid [8];
    logic [2:0] m_tag   [8];
    int         m_left = 0;
    logic [2:0] f_tag   = '0;
    logic [2:0] f_idx   = '0;

    function automatic bit m_hit(input logic [9:0] a);
        return read && m_valid[a[6:4]] && (m_tag[a[6:4]] == a[9:7]);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_valid[i] <= 1'b0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid[f_idx] <= 1'b1;
                m_tag[f_idx]   <= f_tag;
            end
        end else if (read && !m_hit(address)) begin
            m_left <= lat + 2;
            f_tag  <= address[9:7];
            f_idx  <= address[6:4];
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_busywait", busywait, 1'b0);
            chk("rst_instruction", instruction, 32'd0);
        end else if (m_left > 0) begin
            chk("miss_busywait", busywait, 1'b1);
            chk("miss_mem_read", mif.mem_read, m_left > 1);
            if (m_left > 1) chk("miss_mem_address", mif.mem_address, {f_tag, f_idx});
        end else if (read && m_hit(address)) begin
            chk("hit_busywait", busywait, 1'b0);
            chk("hit_mem_read", mif.mem_read, 1'b0);
            chk("hit_instruction", instruction,
                mem_word({address[9:7], address[6:4]}, address[3:2]));
        end else if (read) begin
            chk("detect_busywait", busywait, 1'b1);
            chk("detect_mem_read", mif.mem_read, 1'b0);
        end else begin
            chk("idle_busywait", busywait, 1'b0);
            chk("idle_mem_read", mif.mem_read, 1'b0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Holds the access until busywait falls; returns at the negedge of the hit cycle.
    task automatic access(input logic [9:0] a, output int busy, output logic [5:0] maddr);
        bit done;
        read    = 1'b1;
        address = a;
        busy    = 0;
        maddr   = 6'h3F;
        done    = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clock);
            if (mif.mem_read) maddr = mif.mem_address;
            if (!busywait) done = 1'b1;
            else busy++;
        end
        if (!done) chk("access_timeout", 1'b0, 1'b1);
    endtask

    int         busy;
    logic [5:0] maddr;

    initial begin
        reset   = 1'b1;
        read    = 1'b0;
        address = '0;
        repeat (2) step();
        @(negedge clock);
        chk("reset_mem_read", mif.mem_read, 1'b0);
        chk("reset_mem_address", mif.mem_address, 6'd0);
        step();
        reset = 1'b0;

        // Cold miss, latency 3
        lat = 3;
        access(10'h000, busy, maddr);
        chk("cold_busy_cycles", busy, 6);
        chk("cold_mem_address", maddr, 6'd0);
        chk("cold_instruction", instruction, 32'h00040019);

        // Same-block hits
        step(); address = 10'h004;
        @(negedge clock); chk("hit_w1", instruction, 32'hA0000001); chk("hit_w1_busy", busywait, 1'b0);
        step(); address = 10'h008;
        @(negedge clock); chk("hit_w2", instruction, 32'hA0000002);
        step(); address = 10'h00C;
        @(negedge clock); chk("hit_w3", instruction, 32'hA0000003);

        // Conflict miss on index 0, latency 2
        step();
        lat = 2;
        access(10'h080, busy, maddr);
        chk("conflict_busy_cycles", busy, 5);
        chk("conflict_mem_address", maddr, 6'd8);
        chk("conflict_instruction", instruction, 32'hA0000800);
        step();
        access(10'h000, busy, maddr);
        chk("refetch_mem_address", maddr, 6'd0);
        chk("refetch_busy_cycles", busy, 5);
        chk("refetch_instruction", instruction, 32'h00040019);

        // read low on an uncached address
        step();
        read = 1'b0; address = 10'h3F0;
        @(negedge clock); chk("noread_busy", busywait, 1'b0); chk("noread_mem_read", mif.mem_read, 1'b0);
        step();
        @(negedge clock); chk("noread_mem_read2", mif.mem_read, 1'b0);

        // Address change mid-miss: the latched line (block 63) is still filled
        step();
        read = 1'b1; address = 10'h3F0;
        step();
        address = 10'h004;
        begin
            bit done = 1'b0;
            for (int n = 0; n < 100 && !done; n++) begin
                @(negedge clock);
                if (!busywait) done = 1'b1;
            end
            if (!done) chk("midmiss_timeout", 1'b0, 1'b1);
        end
        chk("midmiss_reeval", instruction, 32'hA0000001);
        step(); address = 10'h3F4;
        @(negedge clock);
        chk("midmiss_filled_busy", busywait, 1'b0);
        chk("midmiss_filled_instr", instruction, 32'hA0003F01);

        // Reset during MEM_READ
        step();
        address = 10'h100;
        step();
        step();
        chk("pre_reset_mem_read", mif.mem_read, 1'b1);
        reset = 1'b1; read = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_mem_read", mif.mem_read, 1'b0);
        chk("post_reset_busywait", busywait, 1'b0);
        step();
        access(10'h000, busy, maddr);
        chk("post_reset_miss_cycles", busy, 5);
        chk("post_reset_mem_address", maddr, 6'd0);
        chk("post_reset_instruction", instruction, 32'h00040019);

`ifdef ICACHE_STATS_EN
        step();
        reset = 1'b1; read = 1'b0;
        step();
        reset = 1'b0;
        access(10'h000, busy, maddr); step();
        access(10'h004, busy, maddr); step();
        access(10'h080, busy, maddr); step();
        access(10'h000, busy, maddr); step();
        read = 1'b0;
        @(negedge clock);
        chk("stats_miss_count", miss_count, 16'd3);
        chk("stats_hit_count", hit_count, 16'd4);
`endif

        step();
        read = 1'b0;
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the CPU fetch stage and the 16-byte-block instruction memory. Takes the 10-bit byte PC from the CPU and returns the 32-bit instruction in the same cycle on a hit. On a miss it stalls the CPU via `busywait`, fetches the 128-bit block through the memory's `read`/`address`/`readinst`/`busywait` handshake, installs the block, and then serves the hit. It is the initiator side of the instruction-memory block interface.

## Interface
- Parameters: none. Geometry is fixed at 8 lines × 16 B: tag = `address[9:7]`, index = `address[6:4]`, word offset = `address[3:2]`, `address[1:0]` ignored.
- `clock` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: **synchronous, active-high reset.**
- `read` in 1: CPU fetch request; held high with a stable `address` while `busywait` is high.
- `address` in 10: CPU byte PC.
- `instruction` out 32: fetched instruction word.
- `busywait` out 1: CPU stall.
- `mem_read` out 1: block read request to instruction memory.
- `mem_address` out 6: block address {tag, index}.
- `mem_readinst` in 128: returned block; byte *k* is at [8k+7:8k].
- `mem_busywait` in 1: memory busy.
- `hit_count` out 16: present only with `ICACHE_STATS_EN`.
- `miss_count` out 16: present only with `ICACHE_STATS_EN`.

## Operation
- Storage per line: `valid`, 3-bit tag, 128-bit data. No dirty bits and no write path.
- `hit = read & valid[index] & (tag_array[index] == tag)`. This is combinational on `address`.
- `instruction` = data[index] word `offset`, i.e. bits [32·offset+31 : 32·offset]. It is combinational and meaningful only on a hit.
- FSM states are IDLE, MEM_READ, UPDATE.
  - IDLE:
    - `busywait = read & ~hit`.
    - If `read & ~hit` at an edge, latch tag and index into `miss_tag` and `miss_index`, then go to MEM_READ.
  - MEM_READ:
    - `mem_read = 1`, `mem_address = {miss_tag, miss_index}`, `busywait = 1`.
    - At an edge where `mem_busywait == 0`, go to UPDATE.
    - The responder must raise `mem_busywait` within the cycle `mem_read` rises.
  - UPDATE:
    - `mem_read = 0`, `busywait = 1`.
    - At the edge: data[miss_index] ← `mem_readinst`, tag ← miss_tag, valid ← 1, then go to IDLE.
- After returning to IDLE, the hit is re-evaluated from the current `address`. The fill always uses the latched tag and index, even if `address` changed mid-miss.
- `read = 0` never starts a miss and forces `busywait = 0` in IDLE.
- Reset values, applied at an edge with `reset = 1`, override everything else:
  - State returns to IDLE and all valid bits clear.
  - `miss_tag` and `miss_index` clear; counters clear.
  - `mem_read = 0`, `mem_address = 0`, `busywait = 0`, `instruction = 0` (while reset is high).
  - An outstanding memory read is abandoned by dropping `mem_read`.

## Timing
- Hit: zero stall cycles. `instruction` is valid in the same cycle as `address`.
- Miss, with memory holding `mem_busywait` high for L cycles:
  - Cycle 0: detection in IDLE, `busywait` high.
  - L cycles in MEM_READ plus the cycle in which `mem_busywait` is sampled low.
  - 1 cycle in UPDATE.
  - Total `busywait` high = L + 3 cycles. The hit is served in the following cycle.
- `mem_read` is high from the edge entering MEM_READ to the edge entering UPDATE. There is never more than one outstanding request.
- Reset asserted in any state: the next edge gives IDLE with `mem_read = 0`.

## Configuration
- Macro: `ICACHE_STATS_EN`.
- Defined:
  - Adds `hit_count` and `miss_count`, both 16 bits and both saturating at 0xFFFF.
  - `miss_count` increments on each IDLE→MEM_READ transition.
  - `hit_count` increments on each edge in IDLE where `hit` is 1.
  - Both clear on reset.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

## Test plan
- Cold miss: after reset, `read = 1`, `address = 10'h000`; memory block 0 holds 32'h00040019 at word 0.
  - Required: `mem_read` rises with `mem_address = 6'd0`.
  - Required: `busywait` is high for L+3 cycles, then `instruction = 32'h00040019` with `busywait = 0`.
- Same-block hit: `address = 10'h004`, `10'h008`, `10'h00C` in consecutive cycles.
  - Required: `busywait = 0` throughout, `mem_read` never asserts, and the instructions are words 1–3 of block 0.
- Conflict miss: `address = 10'h080` (tag 1, index 0).
  - Required: miss with `mem_address = 6'd8`, then block 8 word 0.
  - Required: `10'h000` then misses again with `mem_address = 6'd0`.
- Idle and address change:
  - `read = 0` with uncached `address = 10'h3F0` gives `busywait = 0` and no `mem_read`.
  - Changing `address` during MEM_READ still fills the latched line; the new address is then re-evaluated.
- Reset mid-miss: assert `reset` for one edge during MEM_READ.
  - Required: the next cycle has `mem_read = 0` and `busywait = 0`.
  - Required: re-reading `10'h000` misses, because all lines are invalid.
- With `ICACHE_STATS_EN`, run the sequence 000, 004, 080, 000, each access held until `busywait` falls.
  - Required: `miss_count = 3`, `hit_count = 4`, counting one post-fill hit per miss plus the hit on 004.
